// File: rtl/based_pkg.sv
// Shared types and constants for the based-literal accumulator.
package based_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int                 RADIX_W        = 5;
  localparam logic [4:0]         SYM_UNDERSCORE = 5'h10;
  localparam logic [RADIX_W-1:0] RADIX_MIN      = 5'd2;
  localparam logic [RADIX_W-1:0] RADIX_MAX      = 5'd16;

endpackage

// File: rtl/based_mac.sv
// Combinational value*radix+digit step, evaluated 5 bits wider than WIDTH so overflow is visible.
// Zero latency; no flow control.
module based_mac
  import based_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   value,
  input  logic [RADIX_W-1:0] radix,
  input  logic [3:0]         digit,
  output logic [WIDTH-1:0]   result,
  output logic               ovf
);

  localparam int EXT_W = WIDTH + 5;

  logic [EXT_W-1:0] full;

  // radix <= 16 and digit <= 15 keep the exact result below 2^(WIDTH+5)
  always_comb begin
    full   = {5'b0, value} * {{WIDTH{1'b0}}, radix} + {{(EXT_W-4){1'b0}}, digit};
    result = full[WIDTH-1:0];
    ovf    = |full[EXT_W-1:WIDTH];
  end

endmodule

// File: rtl/based_literal_accum.sv
// Serial based-literal accumulator; result valid the cycle after the in_last symbol, held until out_ready.
// in_ready drops while a result is pending. BASED_UNDERSCORE_EN enables '_' digit separators.
module based_literal_accum
  import based_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SAT    = 1'b1,
  parameter int NDIG_W = 8
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [RADIX_W-1:0] radix,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_sym,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_value,
  output logic [NDIG_W-1:0]  out_ndig,
  output logic               out_err,
  output logic               out_ovf
);

  state_t state, state_nxt;

  logic [RADIX_W-1:0] radix_q;
  logic [RADIX_W-1:0] eff_radix;
  logic               accept;
  logic               first;
  logic               radix_bad;
  logic               digit_ok;
  logic               us_ok;
  logic               sym_err;
  logic               mac_ovf;
  logic [WIDTH-1:0]   base_value;
  logic [WIDTH-1:0]   mac_value;
  logic [WIDTH-1:0]   value_nxt;
  logic [NDIG_W-1:0]  base_ndig;
  logic [NDIG_W-1:0]  ndig_nxt;
  logic               base_err;
  logic               base_ovf;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
    accept    = in_valid && (state != DONE);
    case (state)
      IDLE:    if (accept)            state_nxt = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // The first symbol of a literal starts from a clean slate and uses the live radix
  always_comb begin
    first      = (state == IDLE);
    eff_radix  = first ? radix : radix_q;
    base_value = first ? '0 : out_value;
    base_ndig  = first ? '0 : out_ndig;
    base_err   = first ? 1'b0 : out_err;
    base_ovf   = first ? 1'b0 : out_ovf;
    radix_bad  = (eff_radix < RADIX_MIN) || (eff_radix > RADIX_MAX);
    digit_ok   = !in_sym[4] && !radix_bad && ({1'b0, in_sym[3:0]} < eff_radix);
  end

`ifdef BASED_UNDERSCORE_EN
  logic prev_us;

  assign us_ok = (in_sym == SYM_UNDERSCORE) && !first && !prev_us && !in_last;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)      prev_us <= 1'b0;
    else if (accept) prev_us <= (in_sym == SYM_UNDERSCORE);
  end
`else
  assign us_ok = 1'b0;
`endif

  based_mac #(
    .WIDTH (WIDTH)
  ) u_mac (
    .value  (base_value),
    .radix  (eff_radix),
    .digit  (in_sym[3:0]),
    .result (mac_value),
    .ovf    (mac_ovf)
  );

  // Once saturated, any further legal step overflows again, so all-ones is self-sustaining
  always_comb begin
    sym_err   = radix_bad || !(digit_ok || us_ok);
    value_nxt = base_value;
    ndig_nxt  = base_ndig;
    if (digit_ok) begin
      value_nxt = (SAT && mac_ovf) ? '1 : mac_value;
      ndig_nxt  = (base_ndig == '1) ? base_ndig : base_ndig + NDIG_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      radix_q   <= '0;
      out_value <= '0;
      out_ndig  <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      radix_q   <= eff_radix;
      out_value <= value_nxt;
      out_ndig  <= ndig_nxt;
      out_err   <= base_err | sym_err;
      out_ovf   <= base_ovf | (digit_ok & mac_ovf);
    end
  end

endmodule

// File: tb/tb_based_literal_accum.sv
// Directed bench: 32-bit saturating instance plus 8-bit saturate/wrap instances sharing one stimulus.
module tb_based_literal_accum;

`ifdef BASED_UNDERSCORE_EN
  localparam bit US = 1'b1;
`else
  localparam bit US = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [4:0]  radix;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_sym;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [7:0]  out_ndig;
  logic        out_err;
  logic        out_ovf;

  logic        rdy_s, vld_s, err_s, ovf_s;
  logic [7:0]  val_s, ndig_s;
  logic        rdy_w, vld_w, err_w, ovf_w;
  logic [7:0]  val_w, ndig_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 sysclk = ~sysclk;

  based_literal_accum #(.WIDTH(32), .SAT(1'b1), .NDIG_W(8)) u_dut (
    .sysclk(sysclk), .rst_n(rst_n), .radix(radix), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_ndig(out_ndig), .out_err(out_err), .out_ovf(out_ovf)
  );

  based_literal_accum #(.WIDTH(8), .SAT(1'b1), .NDIG_W(8)) u_dut8s (
    .sysclk(sysclk), .rst_n(rst_n), .radix(radix), .in_valid(in_valid), .in_ready(rdy_s),
    .in_sym(in_sym), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
    .out_value(val_s), .out_ndig(ndig_s), .out_err(err_s), .out_ovf(ovf_s)
  );

  based_literal_accum #(.WIDTH(8), .SAT(1'b0), .NDIG_W(8)) u_dut8w (
    .sysclk(sysclk), .rst_n(rst_n), .radix(radix), .in_valid(in_valid), .in_ready(rdy_w),
    .in_sym(in_sym), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
    .out_value(val_w), .out_ndig(ndig_w), .out_err(err_w), .out_ovf(ovf_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbols as characters: 0-9 A-F digits, '_' separator, anything else an illegal code
  task automatic send(input logic [4:0] rdx, input string s, input bit end_last);
    byte        ch;
    logic [4:0] sym;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch >= 8'h30 && ch <= 8'h39)      sym = 5'(ch - 8'h30);
      else if (ch >= 8'h41 && ch <= 8'h46) sym = 5'(ch - 8'h41 + 8'd10);
      else if (ch == 8'h5F)                sym = 5'h10;
      else                                 sym = 5'h11;
      radix    = rdx;
      in_sym   = sym;
      in_last  = end_last && (i == s.len() - 1);
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !in_ready; t++) begin
        @(posedge sysclk); #1;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge sysclk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] v, input int nd, input bit e, input bit o);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".value"}, out_value, v);
    chk({tag, ".ndig"},  32'(out_ndig), 32'(nd));
    chk({tag, ".err"},   32'(out_err), 32'(e));
    chk({tag, ".ovf"},   32'(out_ovf), 32'(o));
    @(posedge sysclk); #1;
    chk({tag, ".released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    radix     = 5'd0;
    in_valid  = 1'b0;
    in_sym    = 5'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.value", out_value, 32'd0);
    chk("rst.ndig",  32'(out_ndig), 32'd0);
    chk("rst.err",   32'(out_err), 32'd0);
    chk("rst.ovf",   32'(out_ovf), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    @(posedge sysclk); #1;

    send(5'd10, "1234", 1'b1);           result("dec1234", 32'd1234, 4, 1'b0, 1'b0);
    send(5'd16, "12AF", 1'b1);           result("hex12af", 32'h12AF, 4, 1'b0, 1'b0);
    send(5'd2, "00101101110111", 1'b1);  result("bin", 32'h0B77, 14, 1'b0, 1'b0);
    send(5'd8, "0177362", 1'b1);         result("oct", 32'hFEF2, 7, 1'b0, 1'b0);
    send(5'd11, "01234", 1'b1);          result("r11", 32'd1610, 5, 1'b0, 1'b0);
    send(5'd10, "7", 1'b1);              result("single", 32'd7, 1, 1'b0, 1'b0);

    send(5'd16, "1FF", 1'b1);
    chk("w8sat.value", 32'(val_s), 32'hFF);
    chk("w8sat.ovf",   32'(ovf_s), 32'd1);
    chk("w8wrap.value", 32'(val_w), 32'hFF);
    chk("w8wrap.ovf",   32'(ovf_w), 32'd1);
    result("w32_1ff", 32'h1FF, 3, 1'b0, 1'b0);

    send(5'd16, "1FF0", 1'b1);
    chk("w8sat_hold.value", 32'(val_s), 32'hFF);
    chk("w8wrap_low.value", 32'(val_w), 32'hF0);
    chk("w8wrap_low.ovf",   32'(ovf_w), 32'd1);
    result("w32_1ff0", 32'h1FF0, 4, 1'b0, 1'b0);

    send(5'd8, "192", 1'b1);             result("bad_digit", 32'd10, 2, 1'b1, 1'b0);
    send(5'd17, "5", 1'b1);              result("bad_radix", 32'd0, 0, 1'b1, 1'b0);
    send(5'd10, "1X2", 1'b1);            result("bad_sym", 32'd12, 2, 1'b1, 1'b0);
    send(5'd10, "55", 1'b1);             result("err_cleared", 32'd55, 2, 1'b0, 1'b0);

    send(5'd10, "1_000", 1'b1);          result("us_ok", 32'd1000, 4, !US, 1'b0);
    send(5'd10, "_1", 1'b1);             result("us_first", 32'd1, 1, 1'b1, 1'b0);
    send(5'd10, "1__2", 1'b1);           result("us_double", 32'd12, 2, 1'b1, 1'b0);
    send(5'd10, "1_", 1'b1);             result("us_last", 32'd1, 1, 1'b1, 1'b0);

    out_ready = 1'b0;
    send(5'd10, "42", 1'b1);
    radix    = 5'd10;
    in_sym   = 5'd9;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.value", out_value, 32'd42);
      chk("stall.ndig",  32'(out_ndig), 32'd2);
      chk("stall.ready", 32'(in_ready), 32'd0);
      @(posedge sysclk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    result("stall", 32'd42, 2, 1'b0, 1'b0);

    send(5'd10, "12", 1'b0);
    chk("mid.value", out_value, 32'd12);
    chk("mid.valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("midrst.value", out_value, 32'd0);
    chk("midrst.ndig",  32'(out_ndig), 32'd0);
    chk("midrst.err",   32'(out_err), 32'd0);
    chk("midrst.ovf",   32'(out_ovf), 32'd0);
    chk("midrst.ready", 32'(in_ready), 32'd1);
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge sysclk); #1;
      chk("postrst.valid", 32'(out_valid), 32'd0);
    end
    send(5'd10, "9", 1'b1);              result("recover", 32'd9, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
